// File: rtl/complex_accumulator.sv
// Complex accumulator: sums ACC_LEN signed complex beats per frame and
// holds each finished frame in an output register under backpressure.
// Optional feature macro: CACC_SAT_EN. When it is defined, the narrowed result
// saturates and out_sat is driven. When it is undefined, the result wraps and
// out_sat is tied to 0.
module complex_accumulator #(
  parameter int unsigned IN_W    = 35,
  parameter int unsigned ACC_LEN = 16,
  parameter int unsigned OUT_W   = 36
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_real,
  input  logic signed [IN_W-1:0]  in_imag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_real,
  output logic signed [OUT_W-1:0] out_imag,
  output logic                    out_sat
);

  localparam int unsigned CNT_W = $clog2(ACC_LEN);
  localparam int unsigned ACC_W = IN_W + CNT_W;
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(ACC_LEN - 1);

  logic signed [ACC_W-1:0] acc_r_q, acc_i_q;
  logic signed [ACC_W-1:0] sum_r, sum_i;
  logic [CNT_W-1:0]        count_q;
  logic                    ready_en_q;
  logic                    out_valid_q, out_sat_q;
  logic signed [OUT_W-1:0] out_real_q, out_imag_q;
  logic signed [OUT_W-1:0] res_r, res_i;
  logic                    res_sat;
  logic                    last, accept, pop;

  // Handshake decode; only the last beat of a frame waits on a full output.
  always_comb begin
    last     = (count_q == LastCnt);
    pop      = out_valid_q & out_ready;
    in_ready = ready_en_q & ~clr & ~(last & out_valid_q & ~out_ready);
    accept   = in_valid & in_ready;
    sum_r    = acc_r_q + ACC_W'(in_real);
    sum_i    = acc_i_q + ACC_W'(in_imag);
  end

  if (OUT_W >= ACC_W) begin : g_ext
    // Output is wide enough: plain sign extension, never clips.
    always_comb begin
      res_r   = OUT_W'(sum_r);
      res_i   = OUT_W'(sum_i);
      res_sat = 1'b0;
    end
  end else begin : g_narrow
`ifdef CACC_SAT_EN
    logic ovf_r, ovf_i;
    // Clip when the dropped high bits are not all copies of the sign bit.
    always_comb begin
      ovf_r   = (sum_r[ACC_W-1:OUT_W-1] != {(ACC_W-OUT_W+1){sum_r[ACC_W-1]}});
      ovf_i   = (sum_i[ACC_W-1:OUT_W-1] != {(ACC_W-OUT_W+1){sum_i[ACC_W-1]}});
      res_r   = ovf_r ? {sum_r[ACC_W-1], {(OUT_W-1){~sum_r[ACC_W-1]}}} : sum_r[OUT_W-1:0];
      res_i   = ovf_i ? {sum_i[ACC_W-1], {(OUT_W-1){~sum_i[ACC_W-1]}}} : sum_i[OUT_W-1:0];
      res_sat = ovf_r | ovf_i;
    end
`else
    // Keep the low bits: two's-complement wrap.
    always_comb begin
      res_r   = sum_r[OUT_W-1:0];
      res_i   = sum_i[OUT_W-1:0];
      res_sat = 1'b0;
    end
`endif
  end

  // Partial-sum accumulator and beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r_q    <= '0;
      acc_i_q    <= '0;
      count_q    <= '0;
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (clr || (accept && last)) begin
        acc_r_q <= '0;
        acc_i_q <= '0;
        count_q <= '0;
      end else if (accept) begin
        acc_r_q <= sum_r;
        acc_i_q <= sum_i;
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  // Output register: loads on the last beat, frees on pop; load wins a same-cycle pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_real_q  <= '0;
      out_imag_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (accept && last) begin
      out_valid_q <= 1'b1;
      out_real_q  <= res_r;
      out_imag_q  <= res_i;
      out_sat_q   <= res_sat;
    end else if (pop) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_real  = out_real_q;
  assign out_imag  = out_imag_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_complex_accumulator.sv
// Self-checking bench for complex_accumulator (ACC_LEN=4, IN_W=35, OUT_W=36).
// Honours CACC_SAT_EN the same way as the design build.
module tb_complex_accumulator;

  localparam int IN_W    = 35;
  localparam int ACC_LEN = 4;
  localparam int OUT_W   = 36;

  logic clk = 1'b0;
  logic rst_n;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [IN_W-1:0] in_real = '0;
  logic signed [IN_W-1:0] in_imag = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic signed [OUT_W-1:0] out_real, out_imag;
  logic out_sat;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  complex_accumulator #(.IN_W(IN_W), .ACC_LEN(ACC_LEN), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_imag(in_imag), .out_valid(out_valid), .out_ready(out_ready),
    .out_real(out_real), .out_imag(out_imag), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: fit an exact sum into OUT_W bits.
  function automatic bit clipped(input longint s);
`ifdef CACC_SAT_EN
    return (s > (64'sd1 <<< (OUT_W - 1)) - 1) || (s < -(64'sd1 <<< (OUT_W - 1)));
`else
    return 1'b0;
`endif
  endfunction

  function automatic longint fit(input longint s);
    longint w;
`ifdef CACC_SAT_EN
    if (s > (64'sd1 <<< (OUT_W - 1)) - 1) return (64'sd1 <<< (OUT_W - 1)) - 1;
    if (s < -(64'sd1 <<< (OUT_W - 1)))    return -(64'sd1 <<< (OUT_W - 1));
    return s;
`else
    w = s & ((64'sd1 <<< OUT_W) - 1);
    if (w >= (64'sd1 <<< (OUT_W - 1))) w = w - (64'sd1 <<< OUT_W);
    return w;
`endif
  endfunction

  // Behavioural model: beat index, exact partial sums, one-deep result slot.
  int     m_cnt = 0;
  longint m_sr = 0, m_si = 0, m_or = 0, m_oi = 0;
  bit     m_ov = 0, m_os = 0, m_en = 0;
  int     m_frames = 0;
  int     n_pop = 0;
  logic   exp_ready;

  assign exp_ready = m_en && !clr && !(m_cnt == ACC_LEN - 1 && m_ov && !out_ready);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_sr <= 0; m_si <= 0; m_ov <= 0; m_or <= 0; m_oi <= 0; m_os <= 0;
      m_en <= 0;
    end else begin
      m_en <= 1;
      if (m_ov && out_ready) m_ov <= 0;
      if (clr) begin
        m_cnt <= 0; m_sr <= 0; m_si <= 0;
      end else if (in_valid && exp_ready) begin
        if (m_cnt == ACC_LEN - 1) begin
          m_or     <= fit(m_sr + longint'(in_real));
          m_oi     <= fit(m_si + longint'(in_imag));
          m_os     <= clipped(m_sr + longint'(in_real)) || clipped(m_si + longint'(in_imag));
          m_ov     <= 1;
          m_frames <= m_frames + 1;
          m_cnt <= 0; m_sr <= 0; m_si <= 0;
        end else begin
          m_cnt <= m_cnt + 1;
          m_sr  <= m_sr + longint'(in_real);
          m_si  <= m_si + longint'(in_imag);
        end
      end
    end
  end

  // Count frames actually handed out by the DUT.
  always @(posedge clk) if (rst_n === 1'b1 && out_valid && out_ready) n_pop <= n_pop + 1;

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", longint'(in_ready), longint'(exp_ready));
      check("out_valid", longint'(out_valid), longint'(m_ov));
      if (m_ov) begin
        check("out_real", longint'(out_real), m_or);
        check("out_imag", longint'(out_imag), m_oi);
        check("out_sat", longint'(out_sat), longint'(m_os));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input longint r, input longint i);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_real  = IN_W'(r);
    in_imag  = IN_W'(i);
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 at %0t", $time);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input longint r, input longint i, input bit s);
    check({name, "_valid"}, longint'(out_valid), 1);
    check({name, "_real"}, longint'(out_real), r);
    check({name, "_imag"}, longint'(out_imag), i);
    check({name, "_sat"}, longint'(out_sat), longint'(s));
  endtask

  initial begin
    int cyc, start;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rdy_first_cycle", longint'(in_ready), 0);
    tick();

    // 1: reset mid-frame, then a clean frame of (1,-1).
    out_ready = 1'b1;
    send(7, 7);
    send(7, 7);
    rst_n = 1'b0;
    #1;
    check("rst_valid", longint'(out_valid), 0);
    check("rst_real", longint'(out_real), 0);
    check("rst_imag", longint'(out_imag), 0);
    check("rst_sat", longint'(out_sat), 0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < ACC_LEN; k++) send(1, -1);
    expect_out("t1", 4, -4, 0);

    // 2: streaming frames.
    send(100, 200); send(-50, 7); send(3, -3); send(0, 1);
    expect_out("t2a", 53, 205, 0);
    for (int k = 0; k < ACC_LEN; k++) send(1, 1);
    expect_out("t2b", 4, 4, 0);
    tick();

    // 3: backpressure; the 8th beat stalls until the held frame is taken.
    out_ready = 1'b0;
    send(1, 1); send(2, 2); send(3, 3); send(4, 4);
    expect_out("t3a", 10, 10, 0);
    for (int k = 0; k < 3; k++) send(10, -1);
    in_valid = 1'b1;
    in_real  = IN_W'(10);
    in_imag  = -IN_W'(1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_stall", longint'(in_ready), 0);
      check("t3_hold", longint'(out_real), 10);
    end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("t3_popaccept", longint'(in_ready), 1);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    expect_out("t3b", 40, -4, 0);

    // 4: clr drops a partial frame and leaves the held output alone.
    send(5, 5); send(5, 5);
    clr = 1'b1; in_valid = 1'b1; in_real = IN_W'(9); in_imag = IN_W'(9);
    tick();
    clr = 1'b0; in_valid = 1'b0;
    expect_out("t4_held", 40, -4, 0);
    for (int k = 0; k < 3; k++) send(1, 2);
    expect_out("t4_held2", 40, -4, 0);
    out_ready = 1'b1;
    send(1, 2);
    expect_out("t4", 4, 8, 0);

    // 5: overflow of the output width.
    for (int k = 0; k < ACC_LEN; k++) send((64'sd1 <<< 34) - 1, -(64'sd1 <<< 34));
`ifdef CACC_SAT_EN
    expect_out("t5", (64'sd1 <<< 35) - 1, -(64'sd1 <<< 35), 1);
`else
    expect_out("t5", -4, 0, 0);
`endif
    tick();

    // 6: random traffic, 1000 frames.
    start = m_frames;
    cyc = 0;
    while (m_frames - start < 1000 && cyc < 40000) begin
      in_valid  = ($urandom_range(3) != 0);
      clr       = ($urandom_range(99) == 0);
      out_ready = ($urandom_range(2) != 0);
      in_real   = IN_W'({$urandom, $urandom});
      in_imag   = IN_W'({$urandom, $urandom});
      tick();
      cyc++;
    end
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("t6_frames_done", longint'(m_frames - start >= 1000), 1);
    repeat (3) tick();
    check("frames_popped", longint'(n_pop), longint'(m_frames));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
